mux_2x32: RTL and testbench



---
 rtl/mux_2x32.sv | 37 +++
 tb/tb_mux_2x32.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/mux_2x32.sv
// mux_2x32: two-input word selector; y is combinational, y_q is its registered copy.
// Latency: y 0 cycles, y_q 1 cycle; no backpressure, so every cycle is accepted.
module mux_2x32 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] a1,
    input  logic             s,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q
);

    logic [WIDTH-1:0] w_sel;
    logic [WIDTH-1:0] r_y_q;

    // An unknown select falls into the else branch, so X/Z on s picks a0.
    always_comb begin
        w_sel = a0;
        if (s == 1'b1) begin
            w_sel = a1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_y_q <= '0;
        end else begin
            r_y_q <= w_sel;
        end
    end

    assign y   = w_sel;
    assign y_q = r_y_q;

endmodule

// File: tb/tb_mux_2x32.sv
// Directed bench for mux_2x32: combinational select, registered copy and reset.
module tb_mux_2x32;

    logic        clk;
    logic        rst;
    logic [31:0] a0;
    logic [31:0] a1;
    logic        s;
    logic [31:0] y;
    logic [31:0] y_q;

    int tests_run = 0;
    int tests_failed = 0;

    mux_2x32 #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .a0  (a0),
        .a1  (a1),
        .s   (s),
        .y   (y),
        .y_q (y_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic        exp_s;
        logic [31:0] exp_yq;

        rst = 1'b0;
        a0  = 32'd10;
        a1  = 32'd32;
        s   = 1'b0;

        // Basic selection with 100 ns spacing
        #1;
        chk("sel_s0", y, 32'd10);
        #100;
        s = 1'b1;
        #1;
        chk("sel_s1", y, 32'd32);
        #100;
        s = 1'b0;
        #1;
        chk("sel_s0_again", y, 32'd10);

        // Reset held for two edges; y keeps following the inputs
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            chk("rst_yq", y_q, 32'd0);
            chk("rst_y", y, 32'd10);
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_release_yq", y_q, 32'd10);

        // Registered path: toggle s each cycle, y_q lags by one edge
        a0 = 32'hDEADBEEF;
        a1 = 32'h12345678;
        s  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            exp_s  = s;
            exp_yq = exp_s ? 32'h12345678 : 32'hDEADBEEF;
            #1;
            chk("toggle_y", y, exp_yq);
            @(posedge clk);
            #1;
            chk("toggle_yq", y_q, exp_yq);
            s = ~s;
        end

        // Mid-operation reset: in-flight selection discarded, y untouched
        s   = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rst_yq", y_q, 32'd0);
        chk("mid_rst_y", y, 32'h12345678);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_release_yq", y_q, 32'h12345678);

        // All-ones / all-zeros boundary
        a0 = 32'hFFFFFFFF;
        a1 = 32'h00000000;
        s  = 1'b0;
        #1;
        chk("bound_s0", y, 32'hFFFFFFFF);
        s = 1'b1;
        #1;
        chk("bound_s1", y, 32'h00000000);
        @(posedge clk);
        #1;
        chk("bound_yq", y_q, 32'h00000000);

        // Operand changes under a fixed select
        a1 = 32'd32;
        a0 = 32'd10;
        #1;
        chk("fixed_sel_init", y, 32'd32);
        a0 = 32'd99;
        #1;
        chk("fixed_sel_a0_change", y, 32'd32);
        a1 = 32'd7;
        #1;
        chk("fixed_sel_a1_change", y, 32'd7);

        // Simultaneous change of select and operands
        a0 = 32'hA5A5A5A5;
        a1 = 32'h5A5A5A5A;
        s  = 1'b0;
        #1;
        chk("simul_change", y, 32'hA5A5A5A5);

        // Unknown select resolves to a0
        a0 = 32'd5;
        a1 = 32'd6;
        s  = 1'bx;
        #1;
        chk("unknown_sel", y, 32'd5);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
